tetris_board_renderer: RTL and testbench
========================================

# tetris_board_renderer

Pixel-index generator for the playfield: holds the 10×20 board occupancy (3-bit piece type per cell) and, for every VGA pixel coordinate, produces a 4-bit palette index two clocks later. It sits directly upstream of the palette lookup, which converts the index to RGB. It also performs row-collapse after line clears as a multi-cycle shift, so game logic only issues a single request per cleared row.

## Interface
- BOARD_X0, 240, left pixel column of cell (0,0)
- BOARD_Y0, 80, top pixel row of cell (0,0)
- CELL_LOG2, 4, log2 of the cell size in pixels (16 px cells)
- Clk  in  1  pixel clock; all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video, 0 = blanking
- wr_en  in  1  write one board cell this cycle
- wr_col  in  4  cell column, 0..9
- wr_row  in  5  cell row, 0..19 (0 = top)
- wr_type  in  3  0 = empty, 1..7 = I,O,T,S,Z,J,L
- clr_req  in  1  start collapse of row clr_row
- clr_row  in  5  row to remove, 0..19
- clr_busy  out  1  collapse in progress
- index  out  4  palette index for pixel presented two cycles earlier
- index_valid  out  1  delayed copy of blank

## Operation
- Board: 20 rows × 10 cells × 3 bits, all 0 after reset.
- Stage 1 registers: relX = DrawX−BOARD_X0, relY = DrawY−BOARD_Y0 (11-bit signed); region ∈ {BOARD, FRAME, OUTSIDE}; col = relX>>CELL_LOG2, row = relY>>CELL_LOG2; edge = low CELL_LOG2 bits of relX or relY equal 0; blank delayed.
- BOARD: 0 ≤ relX < 160 and 0 ≤ relY < 320. FRAME: not BOARD, and −4 ≤ relX < 164 and −4 ≤ relY < 324. Else OUTSIDE.
- Stage 2 reads cell[row][col] and maps: type 1→5, 2→6, 3→11, 4→1, 5→4, 6→15, 7→12; occupied cell with edge=1 → 13; empty cell → 0; FRAME → 8; OUTSIDE → 0; delayed blank=0 → 0.
- Writes: wr_en with wr_col ≤ 9 and wr_row ≤ 19 updates the cell at the next edge; out-of-range writes ignored; writes ignored while clr_busy=1.
- Row-collapse FSM: IDLE, SHIFT, CLEAR.
  - IDLE: clr_req with clr_row ≤ 19 → load ptr = clr_row. If ptr = 0 → CLEAR, else → SHIFT. clr_row > 19 ignored.
  - SHIFT: row[ptr] ← row[ptr−1]; ptr−1; when ptr reaches 1 the copy is done → CLEAR.
  - CLEAR: row[0] ← 0 → IDLE.
- clr_req while busy ignored. clr_req and wr_en in the same IDLE cycle: collapse starts, write dropped.
- Pixels rendered mid-collapse show the intermediate board; accepted, since game logic collapses during vertical blank.

## Timing
- Reset values: index=0, index_valid=0, clr_busy=0, FSM=IDLE, all cells 0, pipeline registers 0.
- Pixel latency is exactly 2 Clk, fully pipelined with one pixel per clock and no stalls.
- clr_busy rises the edge after the accepted clr_req. The collapse of row R holds busy for R+1 cycles (R SHIFT cycles plus 1 CLEAR cycle), then drops.
- A cell write is visible to a pixel sampled on the cycle after the write edge.
- Reset asserted mid-collapse: FSM returns to IDLE and the board clears to 0 immediately.

## Configuration
- TETRIS_GRID_EN defined: empty BOARD pixels with edge=1 output index 7, drawing a faint grid.
- TETRIS_GRID_EN undefined: empty BOARD pixels always output 0.

## Test plan
- Reset, then sweep DrawX/DrawY with blank=1 → index=0 inside BOARD, 8 on the 4-px frame, 0 outside; index_valid follows blank with 2-cycle delay.
- Write (col 3, row 5, type 1); sample DrawX=296, DrawY=170 → index 5. Sample DrawX=288, DrawY=160 (cell edge) → index 13.
- Fill row 19 with type 2, row 18 with type 4, then clr_req row 19 → clr_busy high for 20 cycles. Afterwards row 19 reads type 4 (index 1) and row 0 is empty.
- clr_req row 0 → busy exactly 1 cycle, row 0 cleared. Second clr_req issued while busy → ignored, board unchanged.
- wr_en with col 10 or row 20 → no change. wr_en and clr_req in the same cycle → collapse happens, write lost.
- With TETRIS_GRID_EN defined: empty cell edge pixel → 7. Without it → 0. Reset asserted mid-collapse → busy=0, index=0, all cells empty.

Source files
------------

// File: rtl/tetris_board_renderer.sv
// tetris_board_renderer
//
// Pixel-index generator for the 10x20 playfield. Holds a 3-bit piece type
// per cell and turns every (DrawX, DrawY) into a 4-bit palette index two
// clocks later. Also collapses a cleared row by shifting every row above it
// down by one, one row per clock, then emptying the top row.
//
// Ports:
//   Clk, Reset_n           pixel clock, asynchronous active-low reset
//   DrawX, DrawY, blank    pixel coordinate and active-video flag (1 = active)
//   wr_en/col/row/type     single-cell board write (ignored while clr_busy)
//   clr_req, clr_row       request removal of one row (ignored while busy)
//   clr_busy               collapse in progress
//   index, index_valid     palette index and delayed blank, 2-cycle latency
//   dbg_state              collapse FSM state (0 idle, 1 shift, 2 clear)
//
// Optional feature: define TETRIS_GRID_EN to draw index 7 on the edge
// pixels of empty board cells (faint grid). Undefined: empty cells are 0.
//
// Handshake: clr_req is a single-cycle request sampled only while clr_busy
// is low; clr_busy rises on the following edge and stays high for
// clr_row+1 cycles. There is no back-pressure on the pixel stream.

module tetris_board_renderer #(
  parameter int BOARD_X0  = 240,
  parameter int BOARD_Y0  = 80,
  parameter int CELL_LOG2 = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic       wr_en,
  input  logic [3:0] wr_col,
  input  logic [4:0] wr_row,
  input  logic [2:0] wr_type,
  input  logic       clr_req,
  input  logic [4:0] clr_row,
  output logic       clr_busy,
  output logic [3:0] index,
  output logic       index_valid,
  output logic [1:0] dbg_state
);

  localparam int ROWS = 20;
  localparam int COLS = 10;

  localparam logic signed [10:0] X0_S   = 11'(BOARD_X0);
  localparam logic signed [10:0] Y0_S   = 11'(BOARD_Y0);
  localparam logic signed [10:0] W_S    = 11'(COLS << CELL_LOG2);
  localparam logic signed [10:0] H_S    = 11'(ROWS << CELL_LOG2);
  localparam logic signed [10:0] MARGIN = 11'sd4;
  localparam logic signed [10:0] ZERO_S = 11'sd0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_CLEAR = 2'd2} clr_state_e;
  typedef enum logic [1:0] {R_OUT = 2'd0, R_BOARD = 2'd1, R_FRAME = 2'd2} region_e;

  // Board storage and collapse FSM state
  logic [2:0] board_q [ROWS][COLS];
  logic [2:0] board_d [ROWS][COLS];
  clr_state_e state_q, state_d;
  logic [4:0] ptr_q, ptr_d;

  // Stage 1 registers
  region_e    region_q, region_d;
  logic [3:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic       edge_q, edge_d;
  logic       vis_q, vis_d;

  // Stage 2 registers
  logic [3:0] index_q, index_d;
  logic       index_valid_q, index_valid_d;

  logic signed [10:0] rel_x, rel_y;
  logic               in_board, in_frame_box;
  logic [2:0]         cell_type;

  function automatic logic [3:0] piece_color(input logic [2:0] t);
    case (t)
      3'd1:    piece_color = 4'd5;
      3'd2:    piece_color = 4'd6;
      3'd3:    piece_color = 4'd11;
      3'd4:    piece_color = 4'd1;
      3'd5:    piece_color = 4'd4;
      3'd6:    piece_color = 4'd15;
      3'd7:    piece_color = 4'd12;
      default: piece_color = 4'd0;
    endcase
  endfunction

  // Stage 1: classify the pixel relative to the board origin.
  always_comb begin
    rel_x        = $signed({1'b0, DrawX}) - X0_S;
    rel_y        = $signed({1'b0, DrawY}) - Y0_S;
    in_board     = (rel_x >= ZERO_S) && (rel_x < W_S) && (rel_y >= ZERO_S) && (rel_y < H_S);
    in_frame_box = (rel_x >= -MARGIN) && (rel_x < W_S + MARGIN) &&
                   (rel_y >= -MARGIN) && (rel_y < H_S + MARGIN);
    region_d     = in_board ? R_BOARD : (in_frame_box ? R_FRAME : R_OUT);
    // Zero col/row outside the board so stage 2 never addresses a missing cell.
    col_d        = in_board ? rel_x[CELL_LOG2 +: 4] : 4'd0;
    row_d        = in_board ? rel_y[CELL_LOG2 +: 5] : 5'd0;
    edge_d       = (rel_x[CELL_LOG2-1:0] == '0) || (rel_y[CELL_LOG2-1:0] == '0);
    vis_d        = blank;
  end

  // Stage 2: look up the cell and map it to a palette index.
  always_comb begin
    cell_type = 3'd0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (row_q == 5'(r) && col_q == 4'(c)) cell_type = board_q[r][c];
      end
    end
    index_d       = 4'd0;
    index_valid_d = vis_q;
    if (vis_q) begin
      case (region_q)
        R_BOARD: begin
          if (cell_type != 3'd0) begin
            index_d = edge_q ? 4'd13 : piece_color(cell_type);
          end else begin
`ifdef TETRIS_GRID_EN
            index_d = edge_q ? 4'd7 : 4'd0;
`else
            index_d = 4'd0;
`endif
          end
        end
        R_FRAME: index_d = 4'd8;
        default: index_d = 4'd0;
      endcase
    end
  end

  // Collapse FSM and board update. Writes are only honoured in IDLE and lose
  // to a simultaneous accepted clear request.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    board_d = board_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req && clr_row <= 5'd19) begin
          ptr_d   = clr_row;
          state_d = (clr_row == 5'd0) ? S_CLEAR : S_SHIFT;
        end else if (wr_en && wr_col <= 4'd9 && wr_row <= 5'd19) begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              if (wr_row == 5'(r) && wr_col == 4'(c)) board_d[r][c] = wr_type;
            end
          end
        end
      end
      S_SHIFT: begin
        for (int r = 1; r < ROWS; r++) begin
          if (ptr_q == 5'(r)) begin
            for (int c = 0; c < COLS; c++) board_d[r][c] = board_q[r-1][c];
          end
        end
        ptr_d = ptr_q - 5'd1;
        // Copy into row 1 is the last shift; the top row is emptied next.
        if (ptr_q <= 5'd1) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        for (int c = 0; c < COLS; c++) board_d[0][c] = 3'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= 5'd0;
      region_q      <= R_OUT;
      col_q         <= 4'd0;
      row_q         <= 5'd0;
      edge_q        <= 1'b0;
      vis_q         <= 1'b0;
      index_q       <= 4'd0;
      index_valid_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) board_q[r][c] <= 3'd0;
      end
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      region_q      <= region_d;
      col_q         <= col_d;
      row_q         <= row_d;
      edge_q        <= edge_d;
      vis_q         <= vis_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      board_q       <= board_d;
    end
  end

  assign clr_busy    = (state_q != S_IDLE);
  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tetris_board_renderer.sv
module tb_tetris_board_renderer;

`ifdef TETRIS_GRID_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif
  localparam logic [3:0] GE = GRID ? 4'd7 : 4'd0;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       blank = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_col = '0;
  logic [4:0] wr_row = '0;
  logic [2:0] wr_type = '0;
  logic       clr_req = 1'b0;
  logic [4:0] clr_row = '0;
  logic       clr_busy;
  logic [3:0] index;
  logic       index_valid;
  logic [1:0] dbg_state;

  always #5 Clk = ~Clk;

  tetris_board_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_type(wr_type),
    .clr_req(clr_req), .clr_row(clr_row), .clr_busy(clr_busy),
    .index(index), .index_valid(index_valid), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [2:0] model [20][10];
  logic [3:0] pal [8] = '{4'd0, 4'd5, 4'd6, 4'd11, 4'd1, 4'd4, 4'd15, 4'd12};

  function automatic logic [3:0] model_index(input int x, input int y, input bit b);
    int rx, ry;
    bit e;
    logic [2:0] t;
    if (!b) return 4'd0;
    rx = x - 240;
    ry = y - 80;
    if (rx >= 0 && rx < 160 && ry >= 0 && ry < 320) begin
      t = model[ry / 16][rx / 16];
      e = (rx % 16 == 0) || (ry % 16 == 0);
      if (t != 3'd0) return e ? 4'd13 : pal[t];
      return (GRID && e) ? 4'd7 : 4'd0;
    end
    if (rx >= -4 && rx < 164 && ry >= -4 && ry < 324) return 4'd8;
    return 4'd0;
  endfunction

  task automatic model_clear_all();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) model[r][c] = 3'd0;
  endtask

  // Removing row r: everything above drops by one, a fresh empty row on top.
  task automatic model_remove_row(input int r);
    for (int k = r; k > 0; k--)
      for (int c = 0; c < 10; c++) model[k][c] = model[k-1][c];
    for (int c = 0; c < 10; c++) model[0][c] = 3'd0;
  endtask

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic pipe_drive(input int x, input int y, input bit b);
    logic [4:0] e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    exp_q.push_back({b, model_index(x, y, b)});
    @(posedge Clk); #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      chk("pipe", {index_valid, index}, e);
    end
  endtask

  task automatic pipe_flush();
    logic [4:0] e;
    blank = 1'b0;
    @(posedge Clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pipe_flush", {index_valid, index}, e);
    end
  endtask

  task automatic scan_board();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) pipe_drive(240 + c * 16 + 8, 80 + r * 16 + 8, 1'b1);
    pipe_flush();
  endtask

  task automatic write_cell(input int c, input int r, input int t);
    wr_en = 1'b1;
    wr_col = 4'(c);
    wr_row = 5'(r);
    wr_type = 3'(t);
    @(posedge Clk); #1;
    wr_en = 1'b0;
    if (c <= 9 && r <= 19) model[r][c] = 3'(t);
  endtask

  task automatic do_clear(input int r);
    int cnt;
    clr_req = 1'b1;
    clr_row = 5'(r);
    @(posedge Clk); #1;
    clr_req = 1'b0;
    cnt = 0;
    while (clr_busy && cnt < 64) begin
      cnt++;
      @(posedge Clk); #1;
    end
    chk("busy_cycles", cnt, r + 1);
    model_remove_row(r);
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    model_clear_all();
  endtask

  typedef struct {
    int         x;
    int         y;
    bit         b;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // ---- reset state ----
    model_clear_all();
    apply_reset();
    chk("rst_index", index, 0);
    chk("rst_valid", index_valid, 0);
    chk("rst_busy", clr_busy, 0);

    // ---- directed table: one cell written, frame/board boundaries ----
    write_cell(3, 5, 1);
    vecs.push_back('{296, 170, 1'b1, 4'd5});
    vecs.push_back('{288, 160, 1'b1, 4'd13});
    vecs.push_back('{296, 170, 1'b0, 4'd0});
    vecs.push_back('{240, 80, 1'b1, GE});
    vecs.push_back('{272, 176, 1'b1, GE});
    vecs.push_back('{250, 90, 1'b1, 4'd0});
    vecs.push_back('{399, 399, 1'b1, 4'd0});
    vecs.push_back('{239, 80, 1'b1, 4'd8});
    vecs.push_back('{236, 100, 1'b1, 4'd8});
    vecs.push_back('{235, 100, 1'b1, 4'd0});
    vecs.push_back('{400, 100, 1'b1, 4'd8});
    vecs.push_back('{403, 100, 1'b1, 4'd8});
    vecs.push_back('{404, 100, 1'b1, 4'd0});
    vecs.push_back('{300, 76, 1'b1, 4'd8});
    vecs.push_back('{300, 75, 1'b1, 4'd0});
    vecs.push_back('{300, 403, 1'b1, 4'd8});
    vecs.push_back('{300, 404, 1'b1, 4'd0});
    vecs.push_back('{0, 0, 1'b1, 4'd0});
    for (int i = 0; i < vecs.size(); i++) begin
      DrawX = 10'(vecs[i].x);
      DrawY = 10'(vecs[i].y);
      blank = vecs[i].b;
      @(posedge Clk); #1;
      blank = 1'b0;
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_index", i), index, vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), index_valid, vecs[i].b);
    end

    // ---- collapse of row 19 ----
    for (int c = 0; c < 10; c++) write_cell(c, 19, 2);
    for (int c = 0; c < 10; c++) write_cell(c, 18, 4);
    do_clear(19);
    pipe_drive(248, 392, 1'b1);
    pipe_flush();
    DrawX = 10'd248; DrawY = 10'd392; blank = 1'b1;
    @(posedge Clk); #1; blank = 1'b0; @(posedge Clk); #1;
    chk("row19_after_clear", index, 1);
    scan_board();

    // ---- collapse of row 0, request and write while busy ignored ----
    write_cell(2, 4, 5);
    write_cell(0, 0, 3);
    clr_req = 1'b1; clr_row = 5'd0;
    @(posedge Clk); #1;
    chk("busy_r0_start", clr_busy, 1);
    clr_row = 5'd5;
    wr_en = 1'b1; wr_col = 4'd7; wr_row = 5'd7; wr_type = 3'd7;
    @(posedge Clk); #1;
    clr_req = 1'b0; wr_en = 1'b0;
    chk("busy_r0_end", clr_busy, 0);
    model_remove_row(0);
    scan_board();

    // ---- out-of-range requests ----
    write_cell(10, 0, 7);
    write_cell(15, 3, 6);
    write_cell(0, 20, 5);
    write_cell(4, 31, 3);
    clr_req = 1'b1; clr_row = 5'd20;
    @(posedge Clk); #1;
    clr_req = 1'b0;
    chk("busy_row20", clr_busy, 0);
    scan_board();

    // ---- write and clear in the same cycle ----
    wr_en = 1'b1; wr_col = 4'd1; wr_row = 5'd10; wr_type = 3'd6;
    do_clear(0);
    wr_en = 1'b0;
    scan_board();

    // ---- randomized pixels, writes and collapses ----
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          int c, r, t;
          c = $urandom_range(0, 11);
          r = $urandom_range(0, 21);
          t = $urandom_range(0, 7);
          wr_en = 1'b1; wr_col = 4'(c); wr_row = 5'(r); wr_type = 3'(t);
          if (c <= 9 && r <= 19) model[r][c] = 3'(t);
          pipe_drive($urandom_range(200, 440), $urandom_range(50, 430), 1'b0);
          wr_en = 1'b0;
        end else begin
          pipe_drive($urandom_range(200, 440), $urandom_range(50, 430),
                     $urandom_range(0, 7) != 0);
        end
      end
      pipe_flush();
      do_clear($urandom_range(0, 19));
      scan_board();
    end

    // ---- reset in the middle of a collapse ----
    for (int c = 0; c < 10; c += 3) write_cell(c, 12, 7);
    pipe_drive(248, 88, 1'b1);
    clr_req = 1'b1; clr_row = 5'd19;
    @(posedge Clk); #1;
    clr_req = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    chk("busy_mid_collapse", clr_busy, 1);
    exp_q.delete();
    Reset_n = 1'b0;
    #2;
    chk("rst_mid_busy", clr_busy, 0);
    chk("rst_mid_index", index, 0);
    chk("rst_mid_valid", index_valid, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    model_clear_all();
    scan_board();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
